// File: rtl/wbs_host_arb_pkg.sv
// ---------------------------------------------------------------------------
// wbs_host_arb_pkg
//
// Shared definitions for the two-master Wishbone host arbiter.
//
// Contents:
//   arb_state_t   - 2-bit arbiter FSM state encoding (IDLE, GNT0, GNT1, TMO)
//   TMO_DATA      - read data returned to a master whose cycle timed out
//   TMO_CNT_W     - width of the slave-ack timeout counter
//   grant_onehot  - converts a master index into the one-hot grant vector
// ---------------------------------------------------------------------------
package wbs_host_arb_pkg;

  // The GNT states are encoded so that their bit pattern is already the
  // one-hot grant vector. This keeps the status output easy to read on a
  // waveform.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10,
    ST_TMO  = 2'b11
  } arb_state_t;

  // Recognisable filler data handed back on a timeout termination, so that
  // software reading a dead slave sees an obviously bogus value.
  localparam logic [31:0] TMO_DATA = 32'hDEAD_0BAD;

  // The timeout counter is 16 bits wide, which covers TMO_CYCLES up to 65535.
  localparam int TMO_CNT_W = 16;

  // Master index (0 or 1) to one-hot grant vector.
  function automatic logic [1:0] grant_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wbs_tmo_cnt.sv
// ---------------------------------------------------------------------------
// wbs_tmo_cnt
//
// Slave-ack timeout counter for the Wishbone host arbiter. It counts
// consecutive stall cycles, where the slave strobe is high and no ack has
// come back, and flags the stall cycle that would bring the count up to
// TMO_CYCLES.
//
// Parameters:
//   TMO_CYCLES - number of stall cycles tolerated before a timeout (2..65535)
//
// Ports:
//   i_clk  in   clock
//   i_rst  in   synchronous active-high reset
//   i_clr  in   clear the count (no grant active, or the slave acked)
//   i_inc  in   this cycle is a stall cycle
//   o_hit  out  this stall cycle is the TMO_CYCLES-th one in a row
// ---------------------------------------------------------------------------
module wbs_tmo_cnt
  import wbs_host_arb_pkg::*;
#(
  parameter int TMO_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  // o_hit looks one step ahead. While the register holds TMO_CYCLES-1 and
  // another stall is in progress, this cycle is the one that reaches the
  // limit. The arbiter can then enter TMO on the very next edge. An ack in
  // this cycle drops i_inc, so the ack always beats the timeout.
  localparam logic [TMO_CNT_W-1:0] LAST_STALL = TMO_CNT_W'(TMO_CYCLES - 1);

  logic [TMO_CNT_W-1:0] r_count;

  // Stall counter. Clearing takes priority over counting. Once the hit
  // fires, the arbiter leaves the grant state, so the count never needs
  // to saturate.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + TMO_CNT_W'(1);
    end
  end

  // The hit is purely combinational on the current stall and the stored count.
  always_comb begin
    o_hit = i_inc && (r_count == LAST_STALL);
  end

endmodule

// File: rtl/wbs_host_arb.sv
// ---------------------------------------------------------------------------
// wbs_host_arb
//
// Two-master to one-slave Wishbone arbiter. It uses round-robin priority
// between cycles and holds the grant for the whole bus cycle. A slave-ack
// timeout terminates a stuck cycle with an error and recognisable filler
// data.
//
// Parameters:
//   AW, DW      - Wishbone address / data widths (sel width is DW/8)
//   TMO_CYCLES  - stall cycles tolerated before a timeout termination
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   m0_* / m1_*               master ports: cyc, stb, we, sel, adr, dat in;
//                             ack, err, dat out
//   s_*_o                     slave request: cyc, stb, we, sel, adr, dat
//   s_ack_i, s_dat_i          slave response
//   gnt_o                     one-hot current grant, 00 while idle
//   tmo_flag_o / tmo_clr_i    sticky timeout flag and its clear
// ---------------------------------------------------------------------------
module wbs_host_arb
  import wbs_host_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DW-1:0]     m0_dat_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DW-1:0]     m1_dat_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic              s_ack_i,
  input  logic [DW-1:0]     s_dat_i,

  output logic [1:0]        gnt_o,
  output logic              tmo_flag_o,
  input  logic              tmo_clr_i
);

  // The filler word is fitted to the bus width. Wider buses get zero
  // extension and narrower buses keep the low bits.
  localparam logic [DW-1:0] TMO_DATA_DW = DW'(TMO_DATA);

  arb_state_t r_state;
  arb_state_t w_nextState;

  // r_owner names the master that holds (or is about to hold) the grant.
  // The TMO state needs it to know which master gets the error. When both
  // masters request at once, r_lastGrant picks the one that is not
  // r_lastGrant.
  logic r_owner;
  logic r_lastGrant;
  logic r_tmoFlag;

  logic w_inGrant;
  logic w_ownerCyc;
  logic w_stall;
  logic w_cntClr;
  logic w_tmoHit;

  // Decode the grant and the owner's cycle request. A stall is a granted
  // cycle whose strobe is up with no ack. s_stb_o comes from the master
  // mux only, so no path runs from s_ack_i back onto the slave request.
  always_comb begin
    w_inGrant  = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    w_ownerCyc = r_owner ? m1_cyc_i : m0_cyc_i;
    w_stall    = w_inGrant && s_stb_o && !s_ack_i;
    w_cntClr   = !w_inGrant || s_ack_i;
  end

  // The counter is held at zero outside the grant states. Every entry into
  // GNTN therefore starts from a clean count, including a return from TMO.
  wbs_tmo_cnt #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmoCnt (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_clr (w_cntClr),
    .i_inc (w_stall),
    .o_hit (w_tmoHit)
  );

  // Next-state logic. Arbitration happens only in IDLE, so a granted master
  // keeps the bus for its whole cycle. Dropping cyc always wins over a
  // pending timeout, which also covers a master that abandons a stalled
  // strobe. TMO lasts one cycle, then resumes the owner's grant or goes
  // idle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_nextState = r_lastGrant ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          w_nextState = ST_GNT0;
        end else if (m1_cyc_i) begin
          w_nextState = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!w_ownerCyc) begin
          w_nextState = ST_IDLE;
        end else if (w_tmoHit) begin
          w_nextState = ST_TMO;
        end
      end
      ST_TMO: begin
        if (!w_ownerCyc) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextState = r_owner ? ST_GNT1 : ST_GNT0;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, owner, priority pointer and sticky flag. The pointer moves
  // whenever a bus cycle ends, whether from a grant or from TMO. In that
  // case the departing owner becomes the "last granted" master. Entering
  // TMO sets the flag even if a clear arrives in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_tmoFlag   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == ST_GNT0) begin
        r_owner <= 1'b0;
      end else if (w_nextState == ST_GNT1) begin
        r_owner <= 1'b1;
      end
      if ((r_state != ST_IDLE) && (w_nextState == ST_IDLE)) begin
        r_lastGrant <= r_owner;
      end
      if (w_nextState == ST_TMO) begin
        r_tmoFlag <= 1'b1;
      end else if (tmo_clr_i) begin
        r_tmoFlag <= 1'b0;
      end
    end
  end

  // Output routing. By default everything is quiet, and a late ack that
  // lands while idle goes nowhere. In a grant state the owner's request
  // passes straight to the slave and the slave response passes straight
  // back to it. In TMO the slave is released and the owner gets
  // ack + err with the filler data. gnt_o still shows the owner during TMO,
  // because the owner keeps the bus if its cycle continues.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    gnt_o    = 2'b00;
    case (r_state)
      ST_GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        gnt_o    = grant_onehot(1'b0);
      end
      ST_GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        gnt_o    = grant_onehot(1'b1);
      end
      ST_TMO: begin
        gnt_o = grant_onehot(r_owner);
        if (r_owner) begin
          m1_ack_o = 1'b1;
          m1_err_o = 1'b1;
          m1_dat_o = TMO_DATA_DW;
        end else begin
          m0_ack_o = 1'b1;
          m0_err_o = 1'b1;
          m0_dat_o = TMO_DATA_DW;
        end
      end
      default: begin
      end
    endcase
  end

  // Sticky timeout status.
  always_comb begin
    tmo_flag_o = r_tmoFlag;
  end

endmodule
